// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared state codes and strobe bundles for the pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_MD_BUSY  = 2'd1,
        CTRL_MEM_WAIT = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
    } stall_t;

    typedef struct packed {
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } flush_t;

    localparam stall_t STALL_FRONT = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b0, ex_mem: 1'b0};
    localparam stall_t STALL_TO_EX = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b0};
    localparam stall_t STALL_ALL   = '{pc: 1'b1, if_id: 1'b1, id_ex: 1'b1, ex_mem: 1'b1};

    localparam int TMR_W = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline stages and the stall/flush strobes back to them.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_rs1;
    logic [4:0]       ID_rs2;
    logic             ID_use_rs1;
    logic             ID_use_rs2;
    logic             EX_MemRead;
    logic [4:0]       EX_rd;
    logic             EX_is_muldiv;
    logic             EX_redirect;
    logic             muldiv_done;
    logic             MEM_req;
    logic             MEM_ready;

    logic             PC_stall;
    logic             IF_ID_stall;
    logic             ID_EX_stall;
    logic             EX_MEM_stall;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_flush;
    logic             MEM_WB_flush;
    logic             muldiv_start;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cnt;
    logic             hang_err;

    modport master (
        output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_MemRead, EX_rd,
               EX_is_muldiv, EX_redirect, muldiv_done, MEM_req, MEM_ready,
        input  PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
               muldiv_start, ctrl_state, stall_cnt, hang_err
    );

    modport slave (
        input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2, EX_MemRead, EX_rd,
               EX_is_muldiv, EX_redirect, muldiv_done, MEM_req, MEM_ready,
        output PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
               muldiv_start, ctrl_state, stall_cnt, hang_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl_loaduse_detect.sv
// Load-use compare between the load in EX and the source registers read in ID.
// Purely combinational, zero latency, no backpressure of its own.
module pipeline_hazard_ctrl_loaduse_detect (
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for load-use, redirect, MUL/DIV and data-memory waits.
// Strobes are same-cycle (Mealy); memory wait backpressures every stage up to EX_MEM.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);

    ctrl_state_e      state_q, state_d;
    logic             md_done_q, md_done_d;
    logic [TMR_W-1:0] wait_tmr_q, wait_tmr_inc;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             hang_err_q;
    logic             load_use, mem_blocked, in_wait;
    stall_t           stall;
    flush_t           flush;
    logic             start;

    pipeline_hazard_ctrl_loaduse_detect u_loaduse (
        .id_rs1      (hz.ID_rs1),
        .id_rs2      (hz.ID_rs2),
        .id_use_rs1  (hz.ID_use_rs1),
        .id_use_rs2  (hz.ID_use_rs2),
        .ex_mem_read (hz.EX_MemRead),
        .ex_rd       (hz.EX_rd),
        .load_use    (load_use)
    );

    assign mem_blocked  = hz.MEM_req && !hz.MEM_ready;
    assign in_wait      = (state_q == CTRL_MD_BUSY) || (state_q == CTRL_MEM_WAIT);
    assign wait_tmr_inc = (wait_tmr_q == TMR_LIMIT) ? wait_tmr_q : wait_tmr_q + 1'b1;

    always_comb begin
        stall     = '0;
        flush     = '0;
        start     = 1'b0;
        state_d   = state_q;
        md_done_d = md_done_q;
        case (state_q)
            // MEM_WAIT re-applies rule 1 while blocked; its ready cycle falls through to rules 2-4.
            CTRL_RUN, CTRL_MEM_WAIT: begin
                state_d = CTRL_RUN;
                if (mem_blocked) begin
                    stall        = STALL_ALL;
                    flush.mem_wb = 1'b1;
                    state_d      = CTRL_MEM_WAIT;
                end else if (hz.EX_is_muldiv) begin
                    start        = 1'b1;
                    stall        = STALL_TO_EX;
                    flush.ex_mem = 1'b1;
                    state_d      = CTRL_MD_BUSY;
                end else if (hz.EX_redirect) begin
                    flush.if_id  = 1'b1;
                    flush.id_ex  = 1'b1;
                end else if (load_use) begin
                    stall        = STALL_FRONT;
                    flush.id_ex  = 1'b1;
                end
            end
            CTRL_MD_BUSY: begin
                if (mem_blocked) begin
                    stall        = STALL_ALL;
                    flush.mem_wb = 1'b1;
                    md_done_d    = md_done_q || hz.muldiv_done;
                end else if (hz.muldiv_done || md_done_q) begin
                    md_done_d    = 1'b0;
                    state_d      = CTRL_RUN;
                end else begin
                    stall        = STALL_TO_EX;
                    flush.ex_mem = 1'b1;
                end
            end
            default: begin
                state_d   = CTRL_RUN;
                md_done_d = 1'b0;
            end
        endcase
        if (rst) begin
            stall = '0;
            flush = '0;
            start = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_RUN;
            md_done_q   <= 1'b0;
            wait_tmr_q  <= '0;
            stall_cnt_q <= '0;
            hang_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_done_q <= md_done_d;
            if (in_wait) begin
                wait_tmr_q <= wait_tmr_inc;
                if (wait_tmr_inc == TMR_LIMIT) begin
                    hang_err_q <= 1'b1;
                end
            end else begin
                wait_tmr_q <= '0;
            end
            if (stall.pc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hz.PC_stall     = stall.pc;
    assign hz.IF_ID_stall  = stall.if_id;
    assign hz.ID_EX_stall  = stall.id_ex;
    assign hz.EX_MEM_stall = stall.ex_mem;
    assign hz.IF_ID_flush  = flush.if_id;
    assign hz.ID_EX_flush  = flush.id_ex;
    assign hz.EX_MEM_flush = flush.ex_mem;
    assign hz.MEM_WB_flush = flush.mem_wb;
    assign hz.muldiv_start = start;
    assign hz.ctrl_state   = state_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.hang_err     = hang_err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed multi-cycle sequences, random vs. model.
module tb_pipeline_hazard_ctrl;

    // Strobe vector order: {PC,IF_ID,ID_EX,EX_MEM stall, IF_ID,ID_EX,EX_MEM,MEM_WB flush, start}
    localparam logic [8:0] NONE  = 9'b0000_0000_0;
    localparam logic [8:0] FULL  = 9'b1111_0001_0;
    localparam logic [8:0] MDS   = 9'b1110_0010_0;
    localparam logic [8:0] START = 9'b0000_0000_1;
    localparam logic [8:0] REDIR = 9'b0000_1100_0;
    localparam logic [8:0] LU    = 9'b1100_0100_0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz ();
    pipeline_hazard_ctrl #(.CNT_W(32), .TIMEOUT(255)) dut (.clk(clk), .rst(rst), .hz(hz));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic       u1, u2, memrd;
        logic [4:0] exrd;
        logic       ismd, redir, done, memreq, memrdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        logic [31:0] cnt;
    } vec_t;

    // Reference model state
    int          m_state, m_wait;
    logic        m_pend, m_hang;
    logic [31:0] m_cnt;

    task automatic drive(input in_t i);
        rst             = i.rst;
        hz.ID_rs1       = i.rs1;
        hz.ID_rs2       = i.rs2;
        hz.ID_use_rs1   = i.u1;
        hz.ID_use_rs2   = i.u2;
        hz.EX_MemRead   = i.memrd;
        hz.EX_rd        = i.exrd;
        hz.EX_is_muldiv = i.ismd;
        hz.EX_redirect  = i.redir;
        hz.muldiv_done  = i.done;
        hz.MEM_req      = i.memreq;
        hz.MEM_ready    = i.memrdy;
    endtask

    function automatic logic [8:0] dut_strobes();
        return {hz.PC_stall, hz.IF_ID_stall, hz.ID_EX_stall, hz.EX_MEM_stall,
                hz.IF_ID_flush, hz.ID_EX_flush, hz.EX_MEM_flush, hz.MEM_WB_flush,
                hz.muldiv_start};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input string name, input in_t i, input logic [8:0] exp, input int exp_state);
        @(negedge clk);
        drive(i);
        #1;
        check({name, " strobes"}, 32'(dut_strobes()), 32'(exp));
        check({name, " state"}, 32'(hz.ctrl_state), 32'(exp_state));
        @(posedge clk);
        #1;
    endtask

    function automatic in_t mk(input int rs1, input int rs2, input int u1, input int u2,
                               input int memrd, input int exrd, input int redir);
        in_t t = '0;
        t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.u1 = 1'(u1); t.u2 = 1'(u2);
        t.memrd = 1'(memrd); t.exrd = 5'(exrd); t.redir = 1'(redir);
        return t;
    endfunction

    function automatic logic [8:0] model_out(input in_t i);
        logic blocked, lu;
        blocked = i.memreq && !i.memrdy;
        lu = i.memrd && (i.exrd != 0) &&
             ((i.u1 && i.exrd == i.rs1) || (i.u2 && i.exrd == i.rs2));
        if (i.rst) return NONE;
        if (blocked) return FULL;
        if (m_state == 1) return (i.done || m_pend) ? NONE : MDS;
        if (i.ismd) return MDS | START;
        if (i.redir) return REDIR;
        if (lu) return LU;
        return NONE;
    endfunction

    task automatic model_commit(input in_t i, input logic [8:0] o);
        logic blocked;
        blocked = i.memreq && !i.memrdy;
        if (i.rst) begin
            m_state = 0; m_wait = 0; m_pend = 1'b0; m_hang = 1'b0; m_cnt = '0;
            return;
        end
        if (o[8] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (m_state != 0) begin
            m_wait++;
            if (m_wait >= 255) m_hang = 1'b1;
        end else begin
            m_wait = 0;
        end
        if (m_state == 1) begin
            if (blocked) m_pend = m_pend | i.done;
            else if (i.done || m_pend) begin m_state = 0; m_pend = 1'b0; end
        end else if (blocked) m_state = 2;
        else if (i.ismd) m_state = 1;
        else m_state = 0;
    endtask

    vec_t vt[8];
    in_t  idle, t, r;
    logic [8:0] e;

    initial begin
        idle = '0;
        vt[0] = '{mk(5, 0, 1, 0, 1, 5, 0), LU,    32'd0};
        vt[1] = '{mk(0, 0, 1, 0, 1, 0, 0), NONE,  32'd1};
        vt[2] = '{mk(5, 0, 0, 0, 1, 5, 0), NONE,  32'd1};
        vt[3] = '{mk(3, 7, 1, 1, 1, 7, 0), LU,    32'd1};
        vt[4] = '{mk(9, 0, 1, 0, 0, 9, 0), NONE,  32'd2};
        vt[5] = '{mk(9, 0, 1, 0, 1, 9, 1), REDIR, 32'd2};
        vt[6] = '{mk(0, 0, 0, 0, 0, 0, 1), REDIR, 32'd2};
        vt[7] = '{mk(3, 3, 1, 1, 1, 4, 0), NONE,  32'd2};

        // Reset with hazards asserted: outputs must stay quiet
        t = idle; t.rst = 1'b1; t.ismd = 1'b1; t.memreq = 1'b1;
        drive(t);
        @(posedge clk); #1;
        cyc("reset", t, NONE, 0);
        check("reset cnt", hz.stall_cnt, 32'd0);
        check("reset hang", 32'(hz.hang_err), 32'd0);

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(vt[k].in);
            #1;
            check($sformatf("vec%0d strobes", k), 32'(dut_strobes()), 32'(vt[k].exp));
            check($sformatf("vec%0d state", k), 32'(hz.ctrl_state), 32'd0);
            check($sformatf("vec%0d cnt", k), hz.stall_cnt, vt[k].cnt);
            @(posedge clk); #1;
        end

        // MUL/DIV: done in start cycle ignored, real done 4 cycles later
        t = idle; t.ismd = 1'b1; t.done = 1'b1;
        cyc("md start", t, MDS | START, 0);
        t.done = 1'b0;
        for (int k = 1; k <= 3; k++) cyc("md busy", t, MDS, 1);
        t.done = 1'b1;
        cyc("md done", t, NONE, 1);
        cyc("md after", idle, NONE, 0);
        check("md cnt", hz.stall_cnt, 32'd6);

        t = idle; t.memreq = 1'b1;
        cyc("mem first", t, FULL, 0);
        cyc("mem wait", t, FULL, 2);
        cyc("mem wait", t, FULL, 2);
        t.memrdy = 1'b1;
        cyc("mem ready", t, NONE, 2);
        cyc("mem after", idle, NONE, 0);
        check("mem cnt", hz.stall_cnt, 32'd9);

        t = idle; t.memreq = 1'b1;
        cyc("memmd first", t, FULL, 0);
        t.memrdy = 1'b1; t.ismd = 1'b1;
        cyc("memmd ready start", t, MDS | START, 2);
        t = idle; t.ismd = 1'b1; t.done = 1'b1;
        cyc("memmd done", t, NONE, 1);
        cyc("memmd after", idle, NONE, 0);

        t = idle; t.ismd = 1'b1;
        cyc("ovl start", t, MDS | START, 0);
        t.memreq = 1'b1;
        cyc("ovl wait", t, FULL, 1);
        t.done = 1'b1;
        cyc("ovl wait done", t, FULL, 1);
        t.done = 1'b0;
        cyc("ovl wait", t, FULL, 1);
        t.memrdy = 1'b1;
        cyc("ovl release", t, NONE, 1);
        cyc("ovl after", idle, NONE, 0);
        check("ovl cnt", hz.stall_cnt, 32'd15);

        t = idle; t.memreq = 1'b1;
        for (int k = 0; k <= 300; k++) begin
            @(negedge clk);
            drive(t);
            #1;
            check("hang strobes", 32'(dut_strobes()), 32'(FULL));
            if (k == 255 || k == 256 || k == 300)
                check($sformatf("hang@%0d", k), 32'(hz.hang_err), (k >= 256) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        check("hang state", 32'(hz.ctrl_state), 32'd2);
        check("hang cnt", hz.stall_cnt, 32'd316);
        t.memrdy = 1'b1;
        cyc("hang release", t, NONE, 2);
        check("hang sticky", 32'(hz.hang_err), 32'd1);
        t = idle; t.rst = 1'b1; t.ismd = 1'b1; t.memreq = 1'b1;
        cyc("midrst", t, NONE, 0);
        cyc("postrst", idle, NONE, 0);
        check("postrst cnt", hz.stall_cnt, 32'd0);
        check("postrst hang", 32'(hz.hang_err), 32'd0);

        t = idle; t.rst = 1'b1;
        drive(t);
        @(posedge clk); #1;
        model_commit(t, NONE);
        for (int n = 0; n < 3000; n++) begin
            r = '0;
            r.rst    = ($urandom_range(0, 149) == 0);
            r.rs1    = 5'($urandom_range(0, 3));
            r.rs2    = 5'($urandom_range(0, 3));
            r.u1     = 1'($urandom_range(0, 1));
            r.u2     = 1'($urandom_range(0, 1));
            r.memrd  = 1'($urandom_range(0, 1));
            r.exrd   = 5'($urandom_range(0, 3));
            r.ismd   = ($urandom_range(0, 99) < 15);
            r.redir  = ($urandom_range(0, 99) < 15);
            r.done   = ($urandom_range(0, 99) < 30);
            r.memreq = ($urandom_range(0, 99) < 30);
            r.memrdy = ($urandom_range(0, 99) < 60);
            @(negedge clk);
            drive(r);
            #1;
            e = model_out(r);
            check("rand strobes", 32'(dut_strobes()), 32'(e));
            check("rand state", 32'(hz.ctrl_state), 32'(m_state));
            check("rand cnt", hz.stall_cnt, m_cnt);
            check("rand hang", 32'(hz.hang_err), 32'(m_hang));
            model_commit(r, e);
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
